// File: rtl/murax_board_io.sv
// murax_board_io: board-level button/LED adapter for the Murax GPIO port.
// Buttons are synchronised, debounced and mapped into GPIO read bits, with a
// one-cycle pulse on every debounced press. LEDs follow selected GPIO write bits.
// Optional build macro MURAX_BOARD_IO_LED_PWM_EN adds global PWM brightness on the LEDs.
module murax_board_io #(
    parameter int GPIO_WIDTH        = 32,
    parameter int NUM_BUTTONS       = 2,
    parameter int NUM_LEDS          = 4,
    parameter int BTN_BASE          = 8,
    parameter int BUTTON_ACTIVE_LOW = 0,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter logic [NUM_LEDS*5-1:0] LED_SRC = {5'd7, 5'd2, 5'd1, 5'd0},
    parameter int PWM_BITS          = 8
) (
    input  logic                   io_mainClk,
    input  logic                   io_resetn,
    input  logic [NUM_BUTTONS-1:0] io_buttons,
    input  logic [GPIO_WIDTH-1:0]  io_gpioA_write,
    input  logic [GPIO_WIDTH-1:0]  io_gpioA_writeEnable,
    output logic [GPIO_WIDTH-1:0]  io_gpioA_read,
    input  logic [PWM_BITS-1:0]    io_ledBrightness,
    output logic [NUM_BUTTONS-1:0] io_buttonPress,
    output logic [NUM_LEDS-1:0]    io_leds
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GPIO_WIDTH-1:0] BTN_MASK =
        GPIO_WIDTH'({NUM_BUTTONS{1'b1}}) << BTN_BASE;

    // Parameter sanity: bad configurations must stop elaboration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("murax_board_io: DEBOUNCE_CYCLES must be >= 2");
    end
    if (BTN_BASE + NUM_BUTTONS > GPIO_WIDTH) begin : g_bad_btn_field
        $error("murax_board_io: button field exceeds GPIO_WIDTH");
    end

    logic [GPIO_WIDTH-1:0]  rb_s;        // SoC read-back of driven GPIO bits
    logic [NUM_BUTTONS-1:0] pin_s;       // buttons normalised to active high
    logic [NUM_BUTTONS-1:0] sync1_r;
    logic [NUM_BUTTONS-1:0] sync2_r;
    logic [NUM_BUTTONS-1:0] deb_r;       // debounced state
    logic [NUM_BUTTONS-1:0] deb_dly_r;   // debounced state one cycle late, for edge detect
    logic [CNT_W-1:0]       cnt_r [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] press_r;
    logic [NUM_LEDS-1:0]    led_src_s;
    logic [NUM_LEDS-1:0]    leds_r;

    assign rb_s  = io_gpioA_write & io_gpioA_writeEnable;
    assign pin_s = (BUTTON_ACTIVE_LOW != 0) ? ~io_buttons : io_buttons;

    // Button bits come from the debounced state, everything else is plain read-back.
    assign io_gpioA_read = (rb_s & ~BTN_MASK) | (GPIO_WIDTH'(deb_r) << BTN_BASE);

    // Select each LED's source bit; an index beyond the bus is a build error.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        if (int'(LED_SRC[5*i +: 5]) >= GPIO_WIDTH) begin : g_bad_src
            $error("murax_board_io: LED_SRC entry out of range");
        end
        assign led_src_s[i] = rb_s[LED_SRC[5*i +: 5]];
    end

    // Synchroniser, per-channel debounce counters and press-pulse generation.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            sync1_r   <= {NUM_BUTTONS{1'b0}};
            sync2_r   <= {NUM_BUTTONS{1'b0}};
            deb_r     <= {NUM_BUTTONS{1'b0}};
            deb_dly_r <= {NUM_BUTTONS{1'b0}};
            press_r   <= {NUM_BUTTONS{1'b0}};
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r   <= pin_s;
            sync2_r   <= sync1_r;
            deb_dly_r <= deb_r;
            // Rising edge of the debounced state only; releases never pulse.
            press_r   <= deb_r & ~deb_dly_r;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    // Any agreement restarts the stability window.
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_MAX) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef MURAX_BOARD_IO_LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_r;

    // Free-running PWM counter gates every LED against the global brightness.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
            leds_r    <= {NUM_LEDS{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            leds_r    <= led_src_s & {NUM_LEDS{pwm_cnt_r < io_ledBrightness}};
        end
    end

    logic unused_s;
    assign unused_s = ^rb_s[BTN_BASE +: NUM_BUTTONS];
`else
    // LEDs follow their selected GPIO bits with one cycle of latency.
    always_ff @(posedge io_mainClk) begin
        if (!io_resetn) begin
            leds_r <= {NUM_LEDS{1'b0}};
        end else begin
            leds_r <= led_src_s;
        end
    end

    // Brightness has no effect without PWM; button-position write bits are never read back.
    logic unused_s;
    assign unused_s = ^{rb_s[BTN_BASE +: NUM_BUTTONS], io_ledBrightness};
`endif

    assign io_buttonPress = press_r;
    assign io_leds        = leds_r;

endmodule

// File: tb/tb_murax_board_io.sv
// tb_murax_board_io: directed scenarios plus randomized stimulus for murax_board_io,
// checked every cycle against a history-based reference model.
module tb_murax_board_io;

    localparam int NB     = 2;
    localparam int NL     = 4;
    localparam int BTN_B  = 8;
    localparam int DC     = 4;
    localparam logic [19:0] LED_SRC_T = {5'd7, 5'd2, 5'd1, 5'd0};

    logic          clk = 1'b0;
    logic          resetn;
    logic [NB-1:0] btn;
    logic [31:0]   wr;
    logic [31:0]   we;
    logic [7:0]    bright;
    logic [31:0]   rd;
    logic [NB-1:0] press;
    logic [NL-1:0] leds;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    murax_board_io #(.DEBOUNCE_CYCLES(DC)) dut (
        .io_mainClk          (clk),
        .io_resetn           (resetn),
        .io_buttons          (btn),
        .io_gpioA_write      (wr),
        .io_gpioA_writeEnable(we),
        .io_gpioA_read       (rd),
        .io_ledBrightness    (bright),
        .io_buttonPress      (press),
        .io_leds             (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // hist_m holds the pin value sampled at each of the last 8 edges, newest in the low bits.
    logic [8*NB-1:0] hist_m;
    logic [NB-1:0]   d_m, rose_m, press_m;
    logic [NL-1:0]   leds_m;
    logic [7:0]      pwm_m;

    // A button takes a new level once the synchronised value has shown it for DC
    // consecutive cycles; the synchroniser delays pins by two edges, so the
    // relevant samples are entries 1..DC of the history.
    function automatic logic [NB-1:0] settled(input logic [8*NB-1:0] h, input logic [NB-1:0] d);
        logic [NB-1:0] r;
        r = d;
        for (int i = 0; i < NB; i++) begin
            logic v;
            bit   same;
            v    = h[NB + i];
            same = 1'b1;
            for (int k = 1; k <= DC; k++) if (h[NB*k + i] != v) same = 1'b0;
            if (same) r[i] = v;
        end
        return r;
    endfunction

    function automatic logic [NL-1:0] led_src(input logic [31:0] w, input logic [31:0] e);
        logic [19:0]   map;
        logic [31:0]   rb;
        logic [NL-1:0] r;
        map = LED_SRC_T;
        rb  = w & e;
        for (int i = 0; i < NL; i++) r[i] = rb[map[5*i +: 5]];
        return r;
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] r;
        r = wr & we;
        r[BTN_B +: NB] = d_m;
        return r;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            hist_m  <= '0;
            d_m     <= '0;
            rose_m  <= '0;
            press_m <= '0;
            leds_m  <= '0;
            pwm_m   <= 8'd0;
        end else begin
            d_m     <= settled(hist_m, d_m);
            rose_m  <= settled(hist_m, d_m) & ~d_m;
            press_m <= rose_m;
            hist_m  <= {hist_m[7*NB-1:0], btn};
`ifdef MURAX_BOARD_IO_LED_PWM_EN
            leds_m  <= led_src(wr, we) & {NL{pwm_m < bright}};
`else
            leds_m  <= led_src(wr, we);
`endif
            pwm_m   <= pwm_m + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_read",  rd, exp_read());
            check("mon_press", 32'(press), 32'(press_m));
            check("mon_leds",  32'(leds), 32'(leds_m));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int j;
        int cnt;
        logic [4:0] pat;
        resetn = 1'b0;
        btn    = 2'b11;
        wr     = 32'hFFFF_FFFF;
        we     = 32'hFFFF_FFFF;
        bright = 8'd0;

        // Reset holds everything low even with buttons and GPIO bits all high.
        repeat (3) begin
            tick();
            check("rst_leds",  32'(leds), 32'd0);
            check("rst_press", 32'(press), 32'd0);
            check("rst_read_btn", 32'(rd[9:8]), 32'd0);
            mon_en = 1'b1;
        end

        btn    = 2'b00;
        resetn = 1'b1;
        wr     = 32'hA5A5_A5A5;
        we     = 32'h0000_FFFF;
        #1;
        check("readback", rd, 32'h0000_A4A5);

        // LED mapping: 0x81 sets bits 0 and 7 -> LED0 and LED3.
        wr = 32'h0000_0081;
        we = 32'hFFFF_FFFF;
        tick();
`ifndef MURAX_BOARD_IO_LED_PWM_EN
        check("led_map", 32'(leds), 32'h9);
`endif
        we[7] = 1'b0;
        tick();
`ifndef MURAX_BOARD_IO_LED_PWM_EN
        check("led_we7", 32'(leds), 32'h1);
`endif

        // Clean press on button 0: d rises after the 6th edge from sampling, pulse next.
        btn[0] = 1'b1;
        repeat (5) tick();
        check("press_bit8_early", 32'(rd[8]), 32'd0);
        tick();
        check("press_bit8_rise", 32'(rd[8]), 32'd1);
        tick();
        check("press_pulse", 32'(press), 32'h1);
        tick();
        check("press_pulse_end", 32'(press), 32'h0);

        btn[0] = 1'b0;
        cnt = 0;
        repeat (12) begin
            tick();
            cnt += int'(press[0]);
        end
        check("no_release_pulse", 32'(cnt), 32'd0);
        check("release_bit8", 32'(rd[8]), 32'd0);

        // Bounce on button 1: 1,1,0,1,1 then held high.
        pat = 5'b11011;
        j   = 0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            btn[1] = (k < 5) ? pat[4 - k] : 1'b1;
            tick();
            if (rd[9] && j == 0) j = k + 1;
            cnt += int'(press[1]);
        end
        check("bounce_rise_edge", 32'(j), 32'd9);
        check("bounce_pulses", 32'(cnt), 32'd1);

        // Reset while held: state clears, then the held button is re-debounced and pulses.
        resetn = 1'b0;
        tick();
        check("midrst_bit9", 32'(rd[9]), 32'd0);
        resetn = 1'b1;
        cnt = 0;
        repeat (12) begin
            tick();
            cnt += int'(press[1]);
        end
        check("midrst_repress", 32'(cnt), 32'd1);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            tick();
            resetn = ($urandom_range(0, 399) != 0);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            end
            if ($urandom_range(0, 7) == 0) begin
                wr = $urandom;
                we = $urandom;
            end
            if ($urandom_range(0, 63) == 0) bright = 8'($urandom_range(0, 255));
        end
        resetn = 1'b1;

`ifdef MURAX_BOARD_IO_LED_PWM_EN
        wr     = 32'h0000_0001;
        we     = 32'hFFFF_FFFF;
        bright = 8'd64;
        repeat (3) tick();
        cnt = 0;
        repeat (256) begin
            tick();
            cnt += int'(leds[0]);
        end
        check("pwm_duty_64", 32'(cnt), 32'd64);
        bright = 8'd0;
        repeat (3) tick();
        cnt = 0;
        repeat (256) begin
            tick();
            cnt += int'(leds[0]);
        end
        check("pwm_duty_0", 32'(cnt), 32'd0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
